// File: rtl/nanci_row_loader.sv
`default_nettype none
// ==========================================================================
// nanci_row_loader : FIFO-buffered {addr,data} feeder shifting words row by row into the mesh left edge
// Revision 1.0
// ==========================================================================
module nanci_row_loader #(
  parameter int N          = 4,
  parameter int ROWS       = 4,
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_start,
  input  logic                             i_valid,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_data,
  output logic                             o_ready,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0] o_PE,
  output logic                             o_shift,
  output logic [ROWS-1:0]                  o_row_sel,
  output logic                             o_busy,
  output logic                             o_done
);

  localparam int c_w      = ADDR_WIDTH + DATA_WIDTH;
  localparam int c_word_w = (N > 1) ? $clog2(N) : 1;
  localparam int c_row_w  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w  = c_ptr_w + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [c_word_w-1:0] word_q, word_d;
  logic [c_row_w-1:0]  row_q, row_d;
  logic [c_ptr_w-1:0]  wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0]  rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0]  count_q, count_d;
  logic [c_w-1:0]      pe_q, pe_d;
  logic                shift_q, shift_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ROWS-1:0]     row_sel_q, row_sel_d;
  logic [c_w-1:0]      mem_q [FIFO_DEPTH];

  logic w_push;
  logic w_pop;

  assign o_ready   = (count_q != c_cnt_w'(FIFO_DEPTH));
  assign w_push    = i_valid && o_ready;
  assign w_pop     = (state_q == LOAD) && (count_q != '0);

  assign o_PE      = pe_q;
  assign o_shift   = shift_q;
  assign o_row_sel = row_sel_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;

  // Storage carries no reset; occupancy is governed entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  always_comb begin
    wr_ptr_d = w_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = w_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + c_cnt_w'(1);
      2'b01:   count_d = count_q - c_cnt_w'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    row_d     = row_q;
    pe_d      = pe_q;
    shift_d   = 1'b0;
    done_d    = 1'b0;
    busy_d    = busy_q;
    row_sel_d = row_sel_q;
    case (state_q)
      IDLE: begin
        busy_d    = 1'b0;
        row_sel_d = '0;
        if (i_start) begin
          state_d   = LOAD;
          word_d    = '0;
          row_d     = '0;
          busy_d    = 1'b1;
          row_sel_d = ROWS'(1);
        end
      end
      LOAD: begin
        busy_d    = 1'b1;
        row_sel_d = ROWS'(1) << row_q;
        if (w_pop) begin
          pe_d    = mem_q[rd_ptr_q];
          shift_d = 1'b1;
          word_d  = word_q + 1'b1;
          if (word_q == c_word_w'(N - 1)) begin
            word_d  = '0;
            state_d = (row_q == c_row_w'(ROWS - 1)) ? DONE : GAP;
          end
        end
      end
      GAP: begin
        busy_d    = 1'b1;
        row_d     = row_q + 1'b1;
        row_sel_d = ROWS'(1) << (row_q + 1'b1);
        state_d   = LOAD;
      end
      DONE: begin
        // The done pulse shares its cycle with busy; the row select drops here.
        busy_d    = 1'b1;
        done_d    = 1'b1;
        row_sel_d = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      word_q    <= '0;
      row_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pe_q      <= '0;
      shift_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      row_sel_q <= '0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      row_q     <= row_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pe_q      <= pe_d;
      shift_q   <= shift_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      row_sel_q <= row_sel_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nanci_row_loader.sv
`default_nettype none
// ==========================================================================
// tb_nanci_row_loader : directed self-checking bench for nanci_row_loader
// Revision 1.0
// ==========================================================================
module tb_nanci_row_loader;

  logic       clk;
  logic       rst;

  // Instance A: N=2, ROWS=2
  logic       a_start, a_valid, a_ready, a_shift, a_busy, a_done;
  logic [5:0] a_data, a_pe;
  logic [1:0] a_row_sel;

  // Instance B: N=3, ROWS=2
  logic       b_start, b_valid, b_ready, b_shift, b_busy, b_done;
  logic [5:0] b_data, b_pe;
  logic [1:0] b_row_sel;

  int n_tests = 0;
  int n_fail  = 0;

  logic [5:0] sb_exp [4] = '{6'h28, 6'h30, 6'h38, 6'h3F};

  nanci_row_loader #(.N(2), .ROWS(2), .ADDR_WIDTH(3), .DATA_WIDTH(3), .FIFO_DEPTH(4)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .i_start   (a_start),
    .i_valid   (a_valid),
    .i_data    (a_data),
    .o_ready   (a_ready),
    .o_PE      (a_pe),
    .o_shift   (a_shift),
    .o_row_sel (a_row_sel),
    .o_busy    (a_busy),
    .o_done    (a_done)
  );

  nanci_row_loader #(.N(3), .ROWS(2), .ADDR_WIDTH(3), .DATA_WIDTH(3), .FIFO_DEPTH(4)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .i_start   (b_start),
    .i_valid   (b_valid),
    .i_data    (b_data),
    .o_ready   (b_ready),
    .o_PE      (b_pe),
    .o_shift   (b_shift),
    .o_row_sel (b_row_sel),
    .o_busy    (b_busy),
    .o_done    (b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int shifts;
    int dones;
    int sent;
    int got;
    int starts;

    rst = 1'b0;
    a_start = 0; a_valid = 0; a_data = '0;
    b_start = 0; b_valid = 0; b_data = '0;

    // Reset state
    step(); step();
    @(negedge clk) rst = 1'b1;
    step();
    check("rst_pe",      a_pe, 0);
    check("rst_shift",   a_shift, 0);
    check("rst_row_sel", a_row_sel, 0);
    check("rst_busy",    a_busy, 0);
    check("rst_done",    a_done, 0);
    check("rst_ready",   a_ready, 1);

    // Starvation: empty FIFO, word arrives late
    a_start = 1; step(); a_start = 0;
    check("starve_busy",    a_busy, 1);
    check("starve_row_sel", a_row_sel, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      check("starve_idle_shift", a_shift, 0);
      check("starve_idle_pe",    a_pe, 0);
    end
    a_valid = 1; a_data = 6'h08; step(); a_valid = 0;
    check("starve_push_shift", a_shift, 0);
    check("starve_push_pe",    a_pe, 0);
    step();
    check("starve_arrive_shift", a_shift, 1);
    check("starve_arrive_pe",    a_pe, 6'h08);

    // Reset mid-LOAD with a word still buffered
    a_valid = 1; a_data = 6'h10; step(); a_valid = 0;
    rst = 1'b0;
    #1;
    check("arst_pe",      a_pe, 0);
    check("arst_shift",   a_shift, 0);
    check("arst_row_sel", a_row_sel, 0);
    check("arst_busy",    a_busy, 0);
    check("arst_ready",   a_ready, 1);
    step();
    @(negedge clk) rst = 1'b1;
    step();

    // Full load with backpressure on a fifth word
    a_valid = 1;
    for (int i = 0; i < 4; i++) begin
      a_data = 6'((i + 1) * 8);
      if (i == 3) check("bp_ready_before_4th", a_ready, 1);
      step();
    end
    a_data = 6'h28;
    check("bp_ready_full", a_ready, 0);
    step();
    check("bp_ready_drop", a_ready, 0);
    a_start = 1; step(); a_start = 0;
    check("load_busy",    a_busy, 1);
    check("load_row_sel", a_row_sel, 1);
    check("load_ready",   a_ready, 0);
    step();
    check("load_pe0",     a_pe, 6'h08);
    check("load_shift0",  a_shift, 1);
    check("load_rs0",     a_row_sel, 1);
    check("load_ready_after_pop", a_ready, 1);
    step();
    a_valid = 0;
    check("load_pe1",     a_pe, 6'h10);
    check("load_rs1",     a_row_sel, 1);
    check("load_ready_pushpop", a_ready, 1);
    step();
    check("gap_shift",    a_shift, 0);
    check("gap_row_sel",  a_row_sel, 2);
    step();
    check("load_pe2",     a_pe, 6'h18);
    check("load_rs2",     a_row_sel, 2);
    step();
    check("load_pe3",     a_pe, 6'h20);
    check("load_shift3",  a_shift, 1);
    check("load_rs3",     a_row_sel, 2);
    check("load_nodone",  a_done, 0);
    step();
    check("done_pulse",   a_done, 1);
    check("done_busy",    a_busy, 1);
    check("done_row_sel", a_row_sel, 0);
    check("done_shift",   a_shift, 0);
    step();
    check("idle_busy",    a_busy, 0);
    check("idle_done",    a_done, 0);

    // Start while busy: held fifth word leads the next load
    a_valid = 1;
    a_data = 6'h30; step();
    a_data = 6'h38; step();
    a_data = 6'h3F; step();
    a_valid = 0;
    check("sb_ready_full", a_ready, 0);
    a_start = 1; step(); a_start = 0;
    shifts = 0; dones = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      a_start = (cyc == 3);
      step();
      if (a_shift) begin
        if (shifts < 4) check("sb_pe", a_pe, sb_exp[shifts]);
        shifts++;
      end
      if (a_done) dones++;
    end
    a_start = 0;
    check("sb_shifts", shifts, 4);
    check("sb_dones",  dones, 1);
    check("sb_busy",   a_busy, 0);

    // Wrap-around: 12 words through depth 4 over two N=3, ROWS=2 loads
    sent = 0; got = 0; dones = 0; starts = 0;
    for (int cyc = 0; cyc < 300 && !(got == 12 && dones == 2); cyc++) begin
      b_valid = 0;
      b_start = 0;
      if (b_ready && sent < 12) begin
        b_valid = 1;
        b_data  = 6'(sent + 1);
        sent++;
      end
      if (!b_busy && starts < 2) begin
        b_start = 1;
        starts++;
      end
      step();
      if (b_shift) begin
        check("wrap_pe",  b_pe, got + 1);
        check("wrap_row", b_row_sel, ((got % 6) < 3) ? 1 : 2);
        got++;
      end
      if (b_done) dones++;
    end
    b_valid = 0; b_start = 0;
    check("wrap_count", got, 12);
    check("wrap_dones", dones, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
